// File: rtl/axis_moving_average.sv
// Boxcar mean of the last WINDOW signed samples; one result per accepted sample, ACC_W+2 cycles after accept.
// No output backpressure; tready drops while busy. MOVAVG_WARMUP_SUPPRESS_EN hides the first WINDOW-1 pulses.
module axis_moving_average #(
    parameter int WINDOW = 74,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata
);
    localparam int ACC_W = DATA_W + $clog2(WINDOW);
    localparam int PTR_W = $clog2(WINDOW);
    localparam int REM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);
    localparam logic [REM_W-1:0] DIVISOR  = REM_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DIVIDE, S_OUTPUT} state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic        [DATA_W-1:0] r_mem [WINDOW];
    logic        [PTR_W-1:0]  r_ptr;
    logic        [DATA_W-1:0] r_din;
    logic signed [ACC_W-1:0]  r_sum;
    logic        [ACC_W-1:0]  r_quo;
    logic        [PTR_W-1:0]  r_rem;
    logic                     r_neg;
    logic        [CNT_W-1:0]  r_cnt;
    logic        [DATA_W-1:0] r_tdata;

    logic                     w_accept;
    logic                     w_pulse_en;
    logic signed [ACC_W-1:0]  w_din_ext;
    logic signed [ACC_W-1:0]  w_old_ext;
    logic signed [ACC_W-1:0]  w_sum_nx;
    logic        [ACC_W-1:0]  w_sum_abs;
    logic        [REM_W-1:0]  w_rem_sh;
    logic                     w_ge;
    logic        [PTR_W-1:0]  w_rem_nx;
    logic        [ACC_W-1:0]  w_quo_nx;
    logic        [DATA_W-1:0] w_result;

`ifdef MOVAVG_WARMUP_SUPPRESS_EN
    localparam int FILL_W = $clog2(WINDOW + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WINDOW);
    logic [FILL_W-1:0] r_fill;

    // Counts accepts, so during a result's OUTPUT cycle it already includes that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
        end else if (w_accept && (r_fill != FILL_MAX)) begin
            r_fill <= r_fill + FILL_W'(1);
        end
    end

    assign w_pulse_en = (r_fill == FILL_MAX);
`else
    assign w_pulse_en = 1'b1;
`endif

    assign w_accept  = s_axis_tvalid && s_axis_tready;
    assign w_din_ext = {{(ACC_W-DATA_W){r_din[DATA_W-1]}}, r_din};
    assign w_old_ext = {{(ACC_W-DATA_W){r_mem[r_ptr][DATA_W-1]}}, r_mem[r_ptr]};
    assign w_sum_nx  = r_sum + w_din_ext - w_old_ext;
    assign w_sum_abs = w_sum_nx[ACC_W-1] ? -w_sum_nx : w_sum_nx;

    // One restoring step per cycle: dividend bits shift out of r_quo as quotient bits shift in.
    assign w_rem_sh  = {r_rem, r_quo[ACC_W-1]};
    assign w_ge      = (w_rem_sh >= DIVISOR);
    assign w_rem_nx  = w_ge ? PTR_W'(w_rem_sh - DIVISOR) : PTR_W'(w_rem_sh);
    assign w_quo_nx  = {r_quo[ACC_W-2:0], w_ge};
    assign w_result  = r_neg ? -w_quo_nx[DATA_W-1:0] : w_quo_nx[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_axis_tready = 1'b1;
                if (w_accept) w_state_nx = S_UPDATE;
            end
            S_UPDATE: begin
                w_state_nx = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (r_cnt == CNT_LAST) w_state_nx = S_OUTPUT;
            end
            S_OUTPUT: begin
                s_axis_tready = 1'b1;
                m_axis_tvalid = w_pulse_en;
                w_state_nx    = w_accept ? S_UPDATE : S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr   <= '0;
            r_din   <= '0;
            r_sum   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_tdata <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_OUTPUT: begin
                    if (w_accept) r_din <= s_axis_tdata;
                end
                S_UPDATE: begin
                    r_mem[r_ptr] <= r_din;
                    r_ptr        <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
                    r_sum        <= w_sum_nx;
                    r_quo        <= w_sum_abs;
                    r_rem        <= '0;
                    r_neg        <= w_sum_nx[ACC_W-1];
                    r_cnt        <= '0;
                end
                S_DIVIDE: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) r_tdata <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axis_tdata = r_tdata;

endmodule

// File: tb/tb_axis_moving_average.sv
// Scoreboard bench for axis_moving_average: a reference window model predicts each average and its cycle.
module tb_axis_moving_average;
    localparam int WIN = 74;
    localparam int LAT = 41;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;

    axis_moving_average #(.WINDOW(WIN), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    longint mdl_win [WIN];
    int     mdl_ptr;
    longint mdl_sum;
    int     mdl_fill;
    longint exp_q [$];
    int     lat_q [$];
    longint obs_q [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint obs_at(input int idx);
        if (idx < obs_q.size()) return obs_q[idx];
        return -64'sd999999999;
    endfunction

    task automatic model_clear();
        foreach (mdl_win[i]) mdl_win[i] = 0;
        mdl_ptr  = 0;
        mdl_sum  = 0;
        mdl_fill = 0;
        exp_q.delete();
        lat_q.delete();
        obs_q.delete();
    endtask

    task automatic model_push(input logic signed [31:0] d, input bit keep);
        mdl_sum          = mdl_sum + longint'(d) - mdl_win[mdl_ptr];
        mdl_win[mdl_ptr] = longint'(d);
        mdl_ptr          = (mdl_ptr + 1) % WIN;
        if (mdl_fill < WIN) mdl_fill++;
        if (keep) begin
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
            if (mdl_fill == WIN)
`endif
            begin
                exp_q.push_back(mdl_sum / WIN);
                lat_q.push_back(cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_axis_tvalid === 1'b1) begin
            obs_q.push_back(longint'($signed(m_axis_tdata)));
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                chk("avg_data", $signed(m_axis_tdata), exp_q.pop_front());
                chk("avg_latency", cyc - lat_q.pop_front() + 1, LAT);
            end
        end
    end

    task automatic send(input logic signed [31:0] d, input bit keep);
        int n = 0;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (s_axis_tready !== 1'b1) chk("send_ready_timeout", s_axis_tready, 1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        model_push(d, keep);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tready", s_axis_tready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tvalid", m_axis_tvalid, 0);
        chk("post_rst_tready", s_axis_tready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low_cnt;
        int fifty_cnt;
        rst_n         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        model_clear();

        // single sample: tready shape and latency
        do_reset();
        send(7400, 1);
        low_cnt = 0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k < LAT) begin
                if (s_axis_tready === 1'b0) low_cnt++;
            end else begin
                chk("tready_in_output_cycle", s_axis_tready, 1);
            end
        end
        chk("tready_low_cycles", low_cnt, LAT - 1);
        drain();
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
        chk("single_count", obs_q.size(), 0);
`else
        chk("single_count", obs_q.size(), 1);
        chk("single_value", obs_at(0), 100);
`endif

        // alternating 45/55, sparse
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send((i % 2 == 0) ? 32'sd45 : 32'sd55, 1);
            repeat (98) @(posedge clk);
        end
        drain();
        fifty_cnt = 0;
        foreach (obs_q[i]) if (obs_q[i] == 50) fifty_cnt++;
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
        chk("alt_count", obs_q.size(), 27);
        chk("alt_first", obs_at(0), 50);
        chk("alt_fifty_count", fifty_cnt, 27);
`else
        chk("alt_count", obs_q.size(), 100);
        chk("alt_out1", obs_at(0), 0);
        chk("alt_out2", obs_at(1), 1);
        chk("alt_out74", obs_at(73), 50);
        chk("alt_out100", obs_at(99), 50);
        chk("alt_fifty_count", fifty_cnt, 27);
`endif

        // negative, back-to-back
        do_reset();
        for (int i = 0; i < WIN; i++) send(-32'sd1000, 1);
        drain();
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
        chk("neg_count", obs_q.size(), 1);
        chk("neg_full", obs_at(0), -1000);
`else
        chk("neg_count", obs_q.size(), WIN);
        chk("neg_out1", obs_at(0), -13);
        chk("neg_out74", obs_at(73), -1000);
`endif

        // busy rejection: second beat lands while tready is low
        do_reset();
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 740;
        @(posedge clk);
        #1;
        model_push(740, 1);
        @(negedge clk);
        chk("busy_tready", s_axis_tready, 0);
        s_axis_tdata = 7400;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (60) @(negedge clk);
        drain();
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
        chk("busy_count", obs_q.size(), 0);
`else
        chk("busy_count", obs_q.size(), 1);
        chk("busy_value", obs_at(0), 10);
`endif

        // reset in the middle of a divide
        do_reset();
        send(7400, 0);
        repeat (9) @(posedge clk);
        do_reset();
        send(740, 1);
        repeat (60) @(negedge clk);
        drain();
`ifdef MOVAVG_WARMUP_SUPPRESS_EN
        chk("midrst_count", obs_q.size(), 0);
`else
        chk("midrst_count", obs_q.size(), 1);
        chk("midrst_value", obs_at(0), 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_moving_average.md
Name: axis_moving_average

Overview:
- Streaming boxcar (moving-average) filter on a 32-bit signed AXI4-Stream-style sample stream, for the ECG processing chain (500 Hz samples, 50 MHz clock).
- Each accepted input sample produces one output sample: the mean of the most recent WINDOW inputs.
- The output is a single-cycle valid pulse with no backpressure.

Parameters:
- WINDOW, 74: number of samples averaged. Must be at least 2.
- DATA_W, 32: input/output sample width, signed two's complement.
- ACC_W (derived, localparam): DATA_W + $clog2(WINDOW). Running-sum width; 39 by default.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- s_axis_tvalid, input, 1: input sample valid.
- s_axis_tready, output, 1: block can accept a sample.
- s_axis_tdata, input, DATA_W: signed input sample.
- m_axis_tvalid, output, 1: one-cycle pulse marking a new average.
- m_axis_tdata, output, DATA_W: signed average, held between pulses.

Behaviour:
- Reset (async assert, sync release):
  - Circular buffer of WINDOW entries, write pointer and running sum all cleared to 0.
  - Divider is idle.
  - m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1.
- Handshake:
  - A sample is accepted on a rising edge where s_axis_tvalid && s_axis_tready.
  - s_axis_tvalid while s_axis_tready=0 is ignored; no buffering.
- States:
  - IDLE: tready=1.
  - UPDATE, 1 cycle: sum <= sum + new - buf[ptr]; buf[ptr] <= new; ptr increments, wrapping WINDOW-1 -> 0.
  - DIVIDE, ACC_W cycles: sequential restoring divide of |sum| by WINDOW.
  - OUTPUT, 1 cycle: m_axis_tvalid=1, m_axis_tdata = quotient with sign applied; returns to IDLE.
- s_axis_tready is low from the cycle after acceptance up to, but not including, the OUTPUT cycle. It is high again during the OUTPUT cycle, so back-to-back acceptance is possible.
- Latency:
  - m_axis_tvalid is high exactly ACC_W+2 clock cycles after the accepting edge (41 by default).
  - Pulse width is exactly 1 cycle.
- Arithmetic:
  - Running sum is ACC_W bits signed and never overflows for any DATA_W input.
  - Result = sum / WINDOW, signed, truncated toward zero.
  - Result always fits DATA_W; no saturation is needed.
- Warm-up: the buffer is zero-filled, so the first WINDOW-1 outputs are partial sum / WINDOW. Full-window results start at the WINDOW-th sample.
- m_axis_tdata holds its last value when m_axis_tvalid=0.
- Reset asserted mid-DIVIDE or mid-OUTPUT:
  - Aborts immediately; no pulse is emitted.
  - All state is cleared as above.
- No m_axis_tready input: the downstream sink must always accept.

Optional Feature:
- Macro: MOVAVG_WARMUP_SUPPRESS_EN.
- Defined:
  - A saturating fill counter (0..WINDOW) increments on each accepted sample and is cleared by reset.
  - m_axis_tvalid is suppressed for the first WINDOW-1 results; the first pulse is for the WINDOW-th sample.
  - m_axis_tdata still updates internally. Timing of s_axis_tready is unchanged.
- Undefined: every accepted sample produces a pulse, including the warm-up outputs.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles -> m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1 during reset and after release.
- Single sample and latency:
  - Stimulus: one sample 7400 after reset.
  - Response: m_axis_tdata=100 with a 1-cycle m_axis_tvalid exactly 41 cycles after the accept edge.
  - s_axis_tready low for cycles 1..40 after acceptance.
- Alternating stream:
  - Stimulus: 100 samples alternating 45, 55, one 1-cycle tvalid every 100 clocks.
  - Response: output 1 = 0 (45/74); output 2 = 1 (100/74); outputs 74..100 all = 50.
- Negative truncation:
  - Stimulus: 74 samples of -1000.
  - Response: output 1 = -13 (-13.5 truncated toward zero); output 74 = -1000.
- Busy rejection:
  - Stimulus: s_axis_tvalid high for 2 consecutive cycles with data 740 then 7400.
  - Response: only 740 is accepted; exactly one pulse with value 10.
- Mid-op reset:
  - Stimulus: pulse rst_n low 10 cycles after accepting 7400, then send 740.
  - Response: no pulse for 7400; next output = 10, so the buffer was cleared.
  - With MOVAVG_WARMUP_SUPPRESS_EN defined, the alternating-stream test shows the first pulse at sample 74 with value 50.
